// File: rtl/rf_multiport_sb.sv
// Multi-port register file for the MIPS datapath: NUM_RD combinational read
// ports and two write ports (A: ALU/ID writeback, B: load writeback). It has
// an optional write-to-read bypass and an optional hardwired zero register.
// A per-register busy scoreboard marks operands that in-flight loads still owe.
module rf_multiport_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic                     wr_conflict
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_conflict_q;
    logic                wr_conflict_d;
    logic                wa_ok;
    logic                wb_ok;

    // Qualified write strobes: writes to the zero register are dropped, and
    // nothing is written or bypassed while reset is held.
    always_comb begin
        wa_ok = !rst && wa_en && ((ZERO_REG == 0) || (wa_addr != '0));
        wb_ok = !rst && wb_en && ((ZERO_REG == 0) || (wb_addr != '0));
    end

    // Next register contents; port A is applied last so it wins an address clash.
    always_comb begin
        regs_d = regs_q;
        if (wb_ok) regs_d[wb_addr] = wb_data;
        if (wa_ok) regs_d[wa_addr] = wa_data;
    end

    // Next busy bits: a load writeback clears, a new load issue sets, and set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en)     busy_d[wb_addr]     = 1'b0;
        if (sb_set_en) busy_d[sb_set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // Flag a clash when both ports really write the same register this cycle.
    always_comb begin
        wr_conflict_d = wa_ok && wb_ok && (wa_addr == wb_addr);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    // Combinational read ports. These apply the optional bypass of the winning
    // write and the busy mask on a same-cycle load writeback. The zero register
    // overrides everything.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              bsy;
        ra      = '0;
        rdat    = '0;
        bsy     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra   = rd_addr[i*ADDR_W +: ADDR_W];
            rdat = regs_q[ra];
            bsy  = busy_q[ra];
            if (BYPASS != 0) begin
                if (wb_ok && (wb_addr == ra)) rdat = wb_data;
                if (wa_ok && (wa_addr == ra)) rdat = wa_data;
                if (wb_en && (wb_addr == ra)) bsy  = 1'b0;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rdat = '0;
                bsy  = 1'b0;
            end
            rd_data[i*DATA_W +: DATA_W] = rdat;
            rd_busy[i]                  = bsy;
        end
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Testbench for rf_multiport_sb. The first instance uses the default
// parameters. The second uses the wide, no-bypass variant and runs a random
// stream checked against a reference model.
module tb_rf_multiport_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    // default instance: DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1, BYPASS=1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wa_en, a_wb_en, a_sb_set_en, a_wr_conflict;
    logic [4:0]  a_wa_addr, a_wb_addr, a_sb_set_addr;
    logic [31:0] a_wa_data, a_wb_data;

    rf_multiport_sb dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wa_en(a_wa_en), .wa_addr(a_wa_addr), .wa_data(a_wa_data),
        .wb_en(a_wb_en), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
        .sb_set_en(a_sb_set_en), .sb_set_addr(a_sb_set_addr),
        .wr_conflict(a_wr_conflict)
    );

    // sweep instance: DATA_W=64, ADDR_W=3, NUM_RD=4, BYPASS=0
    logic [11:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wa_en, b_wb_en, b_sb_set_en, b_wr_conflict;
    logic [2:0]   b_wa_addr, b_wb_addr, b_sb_set_addr;
    logic [63:0]  b_wa_data, b_wb_data;

    rf_multiport_sb #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wa_en(b_wa_en), .wa_addr(b_wa_addr), .wa_data(b_wa_data),
        .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
        .sb_set_en(b_sb_set_en), .sb_set_addr(b_sb_set_addr),
        .wr_conflict(b_wr_conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_wa_en = 1'b0; a_wb_en = 1'b0; a_sb_set_en = 1'b0;
    endtask

    task automatic idle_b();
        b_wa_en = 1'b0; b_wb_en = 1'b0; b_sb_set_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        a_rd_addr = {5'd4, 5'd3};
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data !== e) begin n_err++; $display("FAIL reset_init_data: got %h want %h", a_rd_data, e); end
        // preload reg3 via a conflicting write, mark reg4 busy
        a_wa_en = 1'b1; a_wa_addr = 5'd3; a_wa_data = 32'hDEAD_DEAD;
        a_wb_en = 1'b1; a_wb_addr = 5'd3; a_wb_data = 32'h0000_BEEF;
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd4;
        tick(); idle_a();
        exp_q.push_back({31'b0, 1'b1, 32'hDEAD_DEAD});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_data[31:0]} !== e[32:0]) begin n_err++; $display("FAIL preload: got %b/%h want %h", a_wr_conflict, a_rd_data[31:0], e); end
        n_cmp++;
        if (a_rd_busy !== 2'b10) begin n_err++; $display("FAIL preload_busy: got %b want 10", a_rd_busy); end
        // asynchronous assertion away from the clock edge
        rst = 1'b1;
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_busy, a_rd_data} !== {3'b000, e}) begin n_err++; $display("FAIL reset_async: got c=%b b=%b d=%h want all zero", a_wr_conflict, a_rd_busy, a_rd_data); end
        // writes pending under reset are discarded and never bypassed
        a_wa_en = 1'b1; a_wa_addr = 5'd3; a_wa_data = 32'h5555_5555;
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd5;
        a_rd_addr = {5'd5, 5'd3};
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data[31:0] !== e[31:0]) begin n_err++; $display("FAIL reset_no_bypass: got %h want %h", a_rd_data[31:0], e[31:0]); end
        tick();
        rst = 1'b0; idle_a();
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data} !== {2'b00, e}) begin n_err++; $display("FAIL reset_discard: got b=%b d=%h want zero", a_rd_busy, a_rd_data); end
    endtask

    task automatic test_write_read();
        a_wa_en = 1'b1; a_wa_addr = 5'd5; a_wa_data = 32'hDEAD_BEEF;
        a_rd_addr = {5'd5, 5'd5};
        exp_q.push_back({32'hDEAD_BEEF, 32'hDEAD_BEEF});
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data !== e) begin n_err++; $display("FAIL wr_bypass: got %h want %h", a_rd_data, e); end
        tick(); idle_a();
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data[31:0] !== e[31:0]) begin n_err++; $display("FAIL wr_stored: got %h want %h", a_rd_data[31:0], e[31:0]); end
        // top address via port B
        a_wb_en = 1'b1; a_wb_addr = 5'd31; a_wb_data = 32'hA5A5_0031;
        a_rd_addr = {5'd31, 5'd5};
        exp_q.push_back({32'hA5A5_0031, 32'hDEAD_BEEF});
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data !== e) begin n_err++; $display("FAIL wr_top_bypass: got %h want %h", a_rd_data, e); end
        tick(); idle_a();
        exp_q.push_back({32'hA5A5_0031, 32'hDEAD_BEEF});
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data !== e) begin n_err++; $display("FAIL wr_top_stored: got %h want %h", a_rd_data, e); end
    endtask

    task automatic test_zero_reg();
        a_wa_en = 1'b1; a_wa_addr = 5'd0; a_wa_data = 32'h0000_1234;
        a_wb_en = 1'b1; a_wb_addr = 5'd0; a_wb_data = 32'h0000_9999;
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data} !== {2'b00, e}) begin n_err++; $display("FAIL zero_same_cycle: got b=%b d=%h want zero", a_rd_busy, a_rd_data); end
        tick(); idle_a();
        exp_q.push_back(64'h0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_busy, a_rd_data} !== {3'b000, e}) begin n_err++; $display("FAIL zero_after: got c=%b b=%b d=%h want zero", a_wr_conflict, a_rd_busy, a_rd_data); end
    endtask

    task automatic test_conflict();
        a_wa_en = 1'b1; a_wa_addr = 5'd7; a_wa_data = 32'h11;
        a_wb_en = 1'b1; a_wb_addr = 5'd7; a_wb_data = 32'h22;
        a_rd_addr = {5'd7, 5'd7};
        exp_q.push_back({32'h11, 32'h11});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_data} !== {1'b0, e}) begin n_err++; $display("FAIL conflict_bypass: got c=%b d=%h want c=0 d=%h", a_wr_conflict, a_rd_data, e); end
        tick(); idle_a();
        exp_q.push_back({31'b0, 1'b1, 32'h11});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_data[31:0]} !== e[32:0]) begin n_err++; $display("FAIL conflict_pulse: got c=%b d=%h want %h", a_wr_conflict, a_rd_data[31:0], e); end
        tick();
        exp_q.push_back({31'b0, 1'b0, 32'h11});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_wr_conflict, a_rd_data[31:0]} !== e[32:0]) begin n_err++; $display("FAIL conflict_clear: got c=%b d=%h want %h", a_wr_conflict, a_rd_data[31:0], e); end
    endtask

    task automatic test_scoreboard();
        a_rd_addr = {5'd9, 5'd9};
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd9;
        exp_q.push_back(64'd0);
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_busy !== e[1:0]) begin n_err++; $display("FAIL sb_cycle0: got %b want %b", a_rd_busy, e[1:0]); end
        tick(); idle_a();
        exp_q.push_back(64'd3);
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_busy !== e[1:0]) begin n_err++; $display("FAIL sb_cycle1: got %b want %b", a_rd_busy, e[1:0]); end
        tick(); tick();
        a_wb_en = 1'b1; a_wb_addr = 5'd9; a_wb_data = 32'h0000_CAFE;
        exp_q.push_back({30'b0, 2'b00, 32'h0000_CAFE});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data[31:0]} !== e[33:0]) begin n_err++; $display("FAIL sb_wb_mask: got b=%b d=%h want %h", a_rd_busy, a_rd_data[31:0], e); end
        tick(); idle_a();
        exp_q.push_back({30'b0, 2'b00, 32'h0000_CAFE});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data[31:0]} !== e[33:0]) begin n_err++; $display("FAIL sb_wb_done: got b=%b d=%h want %h", a_rd_busy, a_rd_data[31:0], e); end
        // set and clear the same register together: set wins
        a_sb_set_en = 1'b1; a_sb_set_addr = 5'd9;
        a_wb_en = 1'b1; a_wb_addr = 5'd9; a_wb_data = 32'h0000_BEEF;
        tick(); idle_a();
        exp_q.push_back({30'b0, 2'b11, 32'h0000_BEEF});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data[31:0]} !== e[33:0]) begin n_err++; $display("FAIL sb_set_wins: got b=%b d=%h want %h", a_rd_busy, a_rd_data[31:0], e); end
        // port A leaves the busy bit alone
        a_wa_en = 1'b1; a_wa_addr = 5'd9; a_wa_data = 32'h77;
        exp_q.push_back({30'b0, 2'b11, 32'h77});
        #1; e = exp_q.pop_front(); n_cmp++;
        if ({a_rd_busy, a_rd_data[31:0]} !== e[33:0]) begin n_err++; $display("FAIL sb_porta: got b=%b d=%h want %h", a_rd_busy, a_rd_data[31:0], e); end
        tick(); idle_a();
        exp_q.push_back(64'd3);
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_busy !== e[1:0]) begin n_err++; $display("FAIL sb_porta_after: got %b want %b", a_rd_busy, e[1:0]); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            a_wa_en = 1'b1; a_wa_addr = 5'(10 + k); a_wa_data = 32'h1000 + 32'(k);
            a_wb_en = 1'b1; a_wb_addr = 5'(20 + k); a_wb_data = 32'h2000 + 32'(k);
            exp_q.push_back({32'h2000 + 32'(k), 32'h1000 + 32'(k)});
            if (k > 0) begin
                #1; e = exp_q.pop_front(); n_cmp++;
                if (a_rd_data !== e) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", k - 1, a_rd_data, e); end
            end
            tick();
            a_rd_addr = {5'(20 + k), 5'(10 + k)};
        end
        idle_a();
        #1; e = exp_q.pop_front(); n_cmp++;
        if (a_rd_data !== e) begin n_err++; $display("FAIL b2b_5: got %h want %h", a_rd_data, e); end
    endtask

    task automatic test_param_sweep();
        logic [63:0] ref_mem [8];
        logic [7:0]  ref_busy;
        logic [2:0]  ra [4];
        logic [3:0]  exp_busy;
        for (int r = 0; r < 8; r++) ref_mem[r] = 64'h0;
        ref_busy = 8'h0;
        exp_q.push_back(64'd0);
        for (int c = 0; c < 60; c++) begin
            b_wa_en = 1'($urandom_range(0, 1)); b_wa_addr = 3'($urandom_range(0, 7)); b_wa_data = {$urandom, $urandom};
            b_wb_en = 1'($urandom_range(0, 1)); b_wb_addr = 3'($urandom_range(0, 7)); b_wb_data = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b_wb_addr = b_wa_addr;
            b_sb_set_en = 1'($urandom_range(0, 1)); b_sb_set_addr = 3'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++) ra[p] = 3'($urandom_range(0, 7));
            if (c % 3 == 0) ra[1] = b_wa_addr;
            if (c % 4 == 0) ra[3] = ra[0];
            b_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
            exp_busy = '0;
            for (int p = 0; p < 4; p++) begin
                exp_q.push_back((ra[p] == 3'd0) ? 64'h0 : ref_mem[ra[p]]);
                exp_busy[p] = (ra[p] == 3'd0) ? 1'b0 : ref_busy[ra[p]];
            end
            exp_q.push_back({60'b0, exp_busy});
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (b_wr_conflict !== e[0]) begin n_err++; $display("FAIL sweep_conflict c%0d: got %b want %b", c, b_wr_conflict, e[0]); end
            for (int p = 0; p < 4; p++) begin
                e = exp_q.pop_front(); n_cmp++;
                if (b_rd_data[p*64 +: 64] !== e) begin n_err++; $display("FAIL sweep_data c%0d p%0d: got %h want %h", c, p, b_rd_data[p*64 +: 64], e); end
            end
            e = exp_q.pop_front(); n_cmp++;
            if (b_rd_busy !== e[3:0]) begin n_err++; $display("FAIL sweep_busy c%0d: got %b want %b", c, b_rd_busy, e[3:0]); end
            // reference update for the coming edge
            exp_q.push_back({63'b0, (b_wa_en && b_wb_en && (b_wa_addr == b_wb_addr) && (b_wa_addr != 3'd0))});
            if (b_wb_en && b_wb_addr != 3'd0) ref_mem[b_wb_addr] = b_wb_data;
            if (b_wa_en && b_wa_addr != 3'd0) ref_mem[b_wa_addr] = b_wa_data;
            if (b_wb_en) ref_busy[b_wb_addr] = 1'b0;
            if (b_sb_set_en) ref_busy[b_sb_set_addr] = 1'b1;
            ref_busy[0] = 1'b0;
            tick();
        end
        idle_b();
        #1; e = exp_q.pop_front(); n_cmp++;
        if (b_wr_conflict !== e[0]) begin n_err++; $display("FAIL sweep_conflict_last: got %b want %b", b_wr_conflict, e[0]); end
    endtask

    initial begin
        rst = 1'b1;
        idle_a(); idle_b();
        a_wa_addr = '0; a_wa_data = '0; a_wb_addr = '0; a_wb_data = '0;
        a_sb_set_addr = '0; a_rd_addr = '0;
        b_wa_addr = '0; b_wa_data = '0; b_wb_addr = '0; b_wb_data = '0;
        b_sb_set_addr = '0; b_rd_addr = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_back_to_back();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
